// File: rtl/z80_int_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : z80_int_io_responder
// Brief   : Interrupt collector and IM2 vector responder with four IO-mapped
//           control registers (PEND, MASK, VEC, STAT).
// Rev     : 1.0 - initial release
// ============================================================================
module z80_int_io_responder #(
    parameter logic [7:0] BASE_PORT = 8'hF0,
    parameter int         EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    output logic       io_dout_en,
    input  logic       n_m1,
    input  logic       n_iorq,
    input  logic       n_rd,
    input  logic       n_wr,
    input  logic [3:0] irq_src,
    input  logic       nmi_src,
    output logic       int_request_int,
    output logic       int_request_nmi
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [4:0] r_sync1, r_sync2, r_sync3;
    logic [3:0] r_pend;
    logic [7:0] r_mask;
    logic [4:0] r_vec;
    logic [1:0] r_last_src;
    logic [1:0] r_state;
    logic       r_wr_d;
    logic [7:0] r_dout;
    logic       r_dout_en;
    logic       r_int;
    logic       r_nmi;

    logic [4:0] w_hit;
    logic       w_io_sel, w_rd, w_wr_strobe, w_wr_commit, w_ack;
    logic [3:0] w_active, w_clr_wr, w_clr_ack;
    logic [1:0] w_k;
    logic [7:0] w_rdata, w_stat;

    // NMI is always edge-detected so that it yields a single pulse per rise
    assign w_hit[4] = r_sync2[4] & ~r_sync3[4];

    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign w_hit[3:0] = r_sync2[3:0] & ~r_sync3[3:0];
        end else begin : g_level
            assign w_hit[3:0] = r_sync2[3:0];
        end
    endgenerate

    assign w_io_sel    = ~n_iorq & n_m1 & (io_addr[7:2] == BASE_PORT[7:2]);
    assign w_rd        = w_io_sel & ~n_rd;
    assign w_wr_strobe = w_io_sel & ~n_wr;
    assign w_wr_commit = w_wr_strobe & ~r_wr_d;
    assign w_ack       = ~n_m1 & ~n_iorq;
    assign w_active    = r_pend & r_mask[3:0];
    assign w_stat      = {(r_state != S_IDLE), 5'b0, r_last_src};

    always_comb begin
        w_k = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_active[i]) w_k = 2'(i);
        end
    end

    always_comb begin
        case (io_addr[1:0])
            2'd0:    w_rdata = {4'b0, r_pend};
            2'd1:    w_rdata = r_mask;
            2'd2:    w_rdata = {r_vec, 3'b0};
            default: w_rdata = w_stat;
        endcase
    end

    assign w_clr_wr  = (w_wr_commit && io_addr[1:0] == 2'd0) ? io_din[3:0] : 4'b0;
    assign w_clr_ack = (r_state == S_REQ && w_ack && w_active != 4'b0) ? (4'b0001 << w_k) : 4'b0;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_sync1    <= 5'b0;
            r_sync2    <= 5'b0;
            r_sync3    <= 5'b0;
            r_pend     <= 4'b0;
            r_mask     <= 8'h00;
            r_vec      <= 5'b0;
            r_last_src <= 2'd0;
            r_state    <= S_IDLE;
            r_wr_d     <= 1'b0;
            r_dout     <= 8'h00;
            r_dout_en  <= 1'b0;
            r_int      <= 1'b0;
            r_nmi      <= 1'b0;
        end else begin
            r_sync1 <= {nmi_src, irq_src};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_wr_d  <= w_wr_strobe;
            // OR-ing the new hits last makes a same-cycle set win over any clear
            r_pend  <= (r_pend & ~w_clr_wr & ~w_clr_ack) | w_hit[3:0];
            r_nmi   <= w_hit[4];

            if (w_wr_commit) begin
                case (io_addr[1:0])
                    2'd1:    r_mask <= io_din;
                    2'd2:    r_vec  <= io_din[7:3];
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ack) begin
                        r_dout    <= 8'hFF;
                        r_dout_en <= 1'b1;
                        r_int     <= 1'b0;
                        r_state   <= S_ACK;
                    end else begin
                        r_dout    <= w_rd ? w_rdata : 8'h00;
                        r_dout_en <= w_rd;
                        if (w_active != 4'b0) begin
                            r_int   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_int     <= 1'b0;
                        r_dout_en <= 1'b1;
                        r_state   <= S_ACK;
                        if (w_active != 4'b0) begin
                            r_last_src <= w_k;
                            r_dout     <= {r_vec, w_k, 1'b0};
                        end else begin
                            r_dout <= 8'hFF;
                        end
                    end else begin
                        r_dout    <= w_rd ? w_rdata : 8'h00;
                        r_dout_en <= w_rd;
                        if (w_active == 4'b0) begin
                            r_int   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ACK: begin
                    if (n_iorq) begin
                        r_dout    <= 8'h00;
                        r_dout_en <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_dout    <= 8'h00;
                    r_dout_en <= 1'b0;
                    r_int     <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign io_dout         = r_dout;
    assign io_dout_en      = r_dout_en;
    assign int_request_int = r_int;
    assign int_request_nmi = r_nmi;

endmodule
`default_nettype wire

// File: tb/tb_z80_int_io_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_z80_int_io_responder
// Brief   : Directed self-checking bench for z80_int_io_responder.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_z80_int_io_responder;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic [7:0] io_addr = 8'h00;
    logic [7:0] io_din = 8'h00;
    logic [7:0] io_dout;
    logic       io_dout_en;
    logic       n_m1 = 1'b1;
    logic       n_iorq = 1'b1;
    logic       n_rd = 1'b1;
    logic       n_wr = 1'b1;
    logic [3:0] irq_src = 4'b0;
    logic       nmi_src = 1'b0;
    logic       int_request_int;
    logic       int_request_nmi;

    int n_checks = 0;
    int n_errors = 0;

    z80_int_io_responder #(.BASE_PORT(8'hF0), .EDGE_MODE(1)) dut (
        .clk(clk), .n_reset(n_reset), .io_addr(io_addr), .io_din(io_din),
        .io_dout(io_dout), .io_dout_en(io_dout_en), .n_m1(n_m1),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .irq_src(irq_src),
        .nmi_src(nmi_src), .int_request_int(int_request_int),
        .int_request_nmi(int_request_nmi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        io_addr = a; n_iorq = 1'b0; n_rd = 1'b0;
        tick();
        d = io_dout;
        n_iorq = 1'b1; n_rd = 1'b1;
        tick();
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] v);
        io_addr = a; io_din = v; n_iorq = 1'b0; n_wr = 1'b0;
        tick();
        n_iorq = 1'b1; n_wr = 1'b1;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        io_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic ack_begin();
        n_m1 = 1'b0; n_iorq = 1'b0;
        tick();
    endtask

    task automatic ack_end();
        n_m1 = 1'b1; n_iorq = 1'b1;
        tick();
    endtask

    initial begin
        int pulses;
        int first_at;

        // Reset
        n_reset = 1'b0;
        tick(); tick();
        chk("rst_dout", io_dout, 8'h00);
        chk("rst_en", {7'b0, io_dout_en}, 8'h00);
        chk("rst_int", {7'b0, int_request_int}, 8'h00);
        chk("rst_nmi", {7'b0, int_request_nmi}, 8'h00);
        n_reset = 1'b1;
        tick();
        rd_chk("rst_pend", 8'hF0, 8'h00);
        rd_chk("rst_mask", 8'hF1, 8'h00);
        rd_chk("rst_stat", 8'hF3, 8'h00);

        // Single source, vector A8 -> AC
        io_write(8'hF1, 8'h0F);
        io_write(8'hF2, 8'hAD);
        rd_chk("vec_rd", 8'hF2, 8'hA8);
        rd_chk("mask_rd", 8'hF1, 8'h0F);
        irq_src = 4'b0100;
        tick(); tick();
        chk("t1_pend_e2", {4'b0, dut.r_pend}, 8'h00);
        tick();
        chk("t1_pend_e3", {4'b0, dut.r_pend}, 8'h04);
        chk("t1_int_e3", {7'b0, int_request_int}, 8'h00);
        tick();
        chk("t1_int_e4", {7'b0, int_request_int}, 8'h01);
        irq_src = 4'b0;
        ack_begin();
        chk("t1_vec", io_dout, 8'hAC);
        chk("t1_en", {7'b0, io_dout_en}, 8'h01);
        chk("t1_int_ack", {7'b0, int_request_int}, 8'h00);
        chk("t1_pend_ack", {4'b0, dut.r_pend}, 8'h00);
        chk("t1_stat_ack", dut.w_stat, 8'h82);
        tick();
        chk("t1_hold", io_dout, 8'hAC);
        ack_end();
        chk("t1_en_rel", {7'b0, io_dout_en}, 8'h00);
        rd_chk("t1_stat_idle", 8'hF3, 8'h02);

        // Two sources, priority at acknowledge time
        io_write(8'hF2, 8'h00);
        irq_src = 4'b1010;
        tick(); tick(); tick(); tick();
        irq_src = 4'b0;
        chk("t2_int", {7'b0, int_request_int}, 8'h01);
        ack_begin();
        chk("t2_vec1", io_dout, 8'h02);
        ack_end();
        chk("t2_int_idle", {7'b0, int_request_int}, 8'h00);
        tick();
        chk("t2_int_re", {7'b0, int_request_int}, 8'h01);
        ack_begin();
        chk("t2_vec2", io_dout, 8'h06);
        ack_end();
        rd_chk("t2_pend", 8'hF0, 8'h00);

        // Masked source, then unmask and clear while requesting
        io_write(8'hF1, 8'h00);
        irq_src = 4'b0001;
        tick(); tick(); tick(); tick();
        chk("t3_int_masked", {7'b0, int_request_int}, 8'h00);
        rd_chk("t3_pend", 8'hF0, 8'h01);
        io_write(8'hF1, 8'h01);
        chk("t3_int_unmask", {7'b0, int_request_int}, 8'h01);
        io_write(8'hF0, 8'h01);
        chk("t3_int_clr", {7'b0, int_request_int}, 8'h00);
        rd_chk("t3_stat", 8'hF3, 8'h03);
        irq_src = 4'b0;

        // NMI pulses
        nmi_src = 1'b1;
        pulses = 0; first_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (int_request_nmi) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        chk("t4_pulses", 8'(pulses), 8'd1);
        chk("t4_first", 8'(first_at), 8'd3);
        nmi_src = 1'b0;
        tick(); tick(); tick();
        nmi_src = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (int_request_nmi) pulses++;
        end
        chk("t4_pulses2", 8'(pulses), 8'd1);
        nmi_src = 1'b0;

        // Set beats write-1-to-clear in the same cycle
        irq_src = 4'b0010;
        tick(); tick();
        io_write(8'hF0, 8'h02);
        rd_chk("t5_collide", 8'hF0, 8'h02);
        io_write(8'hF0, 8'h02);
        rd_chk("t5_clr", 8'hF0, 8'h00);
        irq_src = 4'b0;

        // Held write strobe commits only once
        io_write(8'hF1, 8'h03);
        io_addr = 8'hF1; io_din = 8'h00; n_iorq = 1'b0; n_wr = 1'b0;
        tick();
        io_din = 8'h0F;
        tick(); tick(); tick(); tick();
        n_iorq = 1'b1; n_wr = 1'b1;
        tick();
        rd_chk("t5_held_wr", 8'hF1, 8'h00);

        // Spurious acknowledge
        ack_begin();
        chk("t6_spur", io_dout, 8'hFF);
        chk("t6_spur_en", {7'b0, io_dout_en}, 8'h01);
        ack_end();
        rd_chk("t6_pend", 8'hF0, 8'h00);

        // Reset in the middle of an acknowledge
        io_write(8'hF2, 8'hF8);
        io_write(8'hF1, 8'h01);
        irq_src = 4'b0001;
        tick(); tick(); tick(); tick();
        irq_src = 4'b0;
        ack_begin();
        chk("t6_vec", io_dout, 8'hF8);
        n_reset = 1'b0;
        tick();
        chk("t6_rst_en", {7'b0, io_dout_en}, 8'h00);
        chk("t6_rst_dout", io_dout, 8'h00);
        chk("t6_rst_int", {7'b0, int_request_int}, 8'h00);
        n_m1 = 1'b1; n_iorq = 1'b1; n_reset = 1'b1;
        tick();
        rd_chk("t6_rst_mask", 8'hF1, 8'h00);
        rd_chk("t6_rst_vec", 8'hF2, 8'h00);
        rd_chk("t6_rst_stat", 8'hF3, 8'h00);
        rd_chk("t6_rst_pend", 8'hF0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z80_int_io_responder.md
Name: z80_int_io_responder

Overview:
Bus-side counterpart of the CPU controller. It responds to the controller's IO strobes (n_iorq, n_rd, n_wr, n_m1) and generates its interrupt inputs (int_request_int, int_request_nmi). It collects four external maskable interrupt sources and one NMI source. It answers the interrupt-acknowledge cycle (n_m1 and n_iorq both low) with an IM2 vector byte, and exposes its control registers as four IO ports.

Parameters:
BASE_PORT, 8'hF0, IO address of register 0; registers occupy BASE_PORT..BASE_PORT+3 (BASE_PORT[1:0] must be 0)
EDGE_MODE, 1, 1 = sources captured on synchronized rising edge; 0 = source level sets pending every cycle it is high

Ports:
clk  in  1  system clock, all logic on rising edge
n_reset  in  1  synchronous active-low reset
io_addr  in  8  low byte of address bus
io_din  in  8  CPU write data
io_dout  out  8  read/vector data to CPU
io_dout_en  out  1  io_dout valid, drive onto data bus
n_m1  in  1  CPU M1 strobe, active low
n_iorq  in  1  CPU IO request, active low
n_rd  in  1  CPU read strobe, active low
n_wr  in  1  CPU write strobe, active low
irq_src  in  4  asynchronous maskable sources; bit 0 highest priority
nmi_src  in  1  asynchronous NMI source
int_request_int  out  1  maskable request to controller, level, registered
int_request_nmi  out  1  NMI request to controller, one-cycle pulse, registered

Behaviour:
- Reset (n_reset=0 at a clk edge): pend=0, mask=0x00 (all masked), vec=0x00, last_src=0, state=IDLE. All outputs 0: io_dout=0x00, io_dout_en=0, int_request_int=0, int_request_nmi=0. Synchronizer flops are cleared. Reset mid-acknowledge drops io_dout_en on the next edge.
- Input path: each irq_src bit and nmi_src pass through a 2-flop synchronizer and then an edge detector. In EDGE_MODE=1, pend[i] is set on the 3rd clk edge after irq_src[i] rises. nmi_src uses the same path and produces an int_request_nmi pulse of exactly 1 cycle, on the edge after the detection edge. A level held high yields no further pulses.
- IO decode: io_sel = n_iorq=0 & n_m1=1 & io_addr[7:2]=BASE_PORT[7:2].
  - Reg 0 PEND: read returns {4'b0,pend}. Write is write-1-to-clear on bits 3:0.
  - Reg 1 MASK: read/write; bit i=1 enables source i.
  - Reg 2 VEC: read/write; only bits 7:3 are stored, and reads return {vec[7:3],3'b0}.
  - Reg 3 STAT: read-only {state!=IDLE, 3'b0, 2'b0, last_src[1:0]}. Writes are ignored.
- Read: while io_sel & n_rd=0, io_dout holds register data and io_dout_en=1. Both are registered, so they are valid from the edge after strobe assertion. Both drop on the edge after n_rd or n_iorq deasserts.
- Write: commits exactly once, on the first edge where io_sel & n_wr=0 (falling-edge detect on the combined strobe). A held strobe does not re-commit.
- Set/clear collision: if a source edge and a write-1-to-clear hit the same pend bit in one cycle, set wins.
- active = pend & mask.
- FSM states:
  - IDLE: if active!=0, go to REQ and assert int_request_int from the next edge.
  - REQ: int_request_int=1.
    - If active becomes 0 (mask/clear write), deassert and return to IDLE.
    - On the first edge with n_m1=0 & n_iorq=0: pick the lowest set index k of active and store last_src=k. Clear pend[k] unless a new edge for k arrives in the same cycle. Set io_dout={vec[7:3],k[1:0],1'b0} and io_dout_en=1. Deassert int_request_int and go to ACK.
  - ACK: hold io_dout/io_dout_en until n_iorq=1, then clear io_dout_en and go to IDLE. The earliest re-request is the edge after IDLE is re-entered.
- Acknowledge seen in IDLE (spurious, or request withdrawn in the same cycle): drive io_dout=0xFF (RST 38h), io_dout_en=1, and go to ACK. Pend is unchanged.
- Priority is evaluated at acknowledge time, not at request time.
- Read and acknowledge are mutually exclusive because the n_m1 qualifier separates them. An IO read or write in REQ state does not change the state.

Test Plan:
1. Reset, then write MASK=0x0F and VEC=0xA8; pulse irq_src[2]. → pend=0x04 on the 3rd edge; int_request_int=1 one edge later. Ack cycle (n_m1=0,n_iorq=0) → io_dout=0xAC, io_dout_en=1, pend=0x00, STAT=0x82 during ACK. After n_iorq=1 → io_dout_en=0 and state IDLE.
2. Set pend bits 1 and 3 together with MASK=0x0F, VEC=0x00. → first ack returns 0x02; int_request_int reasserts after IDLE; second ack returns 0x06; PEND ends at 0x00.
3. With MASK=0x00, raise irq_src[0]. → PEND reads 0x01 and int_request_int stays 0. Write MASK=0x01 → request asserts. Write PEND=0x01 while in REQ → request drops and state returns to IDLE.
4. Drive nmi_src high for 10 cycles. → exactly one 1-cycle int_request_nmi pulse, 3 edges after the rise. Lower and raise again → a second pulse.
5. In the same cycle, write PEND=0x02 and present a synchronized rising edge on irq_src[1]. → PEND reads 0x02 afterwards. Hold n_wr low for 5 cycles with data 0x00 to MASK after setting MASK=0x03 → single commit, MASK=0x00.
6. Ack in IDLE with pend=0. → io_dout=0xFF. Separately, assert n_reset=0 mid-ACK → io_dout_en=0, io_dout=0x00, int_request_int=0 and all registers at reset values on the next edge.
